fetch_redirect_unit: RTL and testbench

Dual-issue front end that supplies instruction pairs to decode/execute. It consumes the execute stage's branch-resolution outputs (isBranchTaken1/2, branchPC1/2) to redirect the PC and squash wrong-path work. It holds a PC register, issues aligned 2-instruction fetches to instruction memory (fixed 1-cycle latency) and buffers returned pairs in a small FIFO. Decode drains the FIFO with a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_redirect_unit.sv | 130 +++++++++++++
 tb/tb_fetch_redirect_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PAIR_BYTES  = 8;

  // One buffered instruction pair; v1/v2 mark which slots are real instructions.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic        v1;
    logic        v2;
  } fetch_entry_t;

  // Base address of the 8-byte pair that contains an address.
  function automatic logic [31:0] pair_base(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF8;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch pairs with clear; push is accepted while full
// when a pop happens in the same cycle. Clear wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer/count values; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Dual-issue fetch front end: PC/redirect control, pair requests to a
// 1-cycle instruction memory, and a credit-managed fetch queue toward decode.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemInst1,
  input  logic [31:0] imemInst2,
  input  logic        isBranchTaken1,
  input  logic [31:0] branchPC1,
  input  logic        isBranchTaken2,
  input  logic [31:0] branchPC2,
  input  logic        decodeReady,
  output logic        fetchValid,
  output logic        fetchValid1,
  output logic        fetchValid2,
  output logic [31:0] fetchPc1,
  output logic [31:0] fetchPc2,
  output logic [31:0] fetchInst1,
  output logic [31:0] fetchInst2,
  output logic        flush
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          skip_first_q, skip_first_d;
  logic          inflight_q, inflight_d;
  logic          tag_q, tag_d;
  logic [31:0]   resp_base_q, resp_base_d;
  logic          flush_q, flush_d;

  logic          redirect;
  logic [31:0]   target;
  logic [CW:0]   credit_sum;
  logic          resp_live;
  logic          pop;
  fetch_entry_t  resp_entry;
  fetch_entry_t  q_head;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;

  // The older execute slot wins when both resolve taken in the same cycle.
  assign redirect = isBranchTaken1 | isBranchTaken2;
  assign target   = isBranchTaken1 ? branchPC1 : branchPC2;

  // Queued plus in-flight pairs never exceed the depth, so a returning pair
  // always finds a free slot.
  assign credit_sum = {1'b0, q_count} + (CW+1)'(inflight_q);
  assign imemReq    = rst_n && !redirect && !q_full && (credit_sum < (CW+1)'(QDEPTH));
  assign imemAddr   = pair_base(pc_q);

  // A response arriving during a redirect is stale; the queue clear drops it.
  assign resp_live  = inflight_q && !redirect;
  assign resp_entry = '{pc: resp_base_q, inst1: imemInst1, inst2: imemInst2,
                        v1: !tag_q, v2: 1'b1};

  // Decode handshake: a pair transfers on any cycle where fetchValid and
  // decodeReady are both high; fetchValid never depends on decodeReady, and
  // the head stays stable until it transfers or a redirect/reset flushes it.
  assign pop = fetchValid && decodeReady;

  // Next PC, skip-first, in-flight tracking and flush pulse.
  always_comb begin
    pc_d         = pc_q;
    skip_first_d = skip_first_q;
    inflight_d   = 1'b0;
    tag_d        = tag_q;
    resp_base_d  = resp_base_q;
    flush_d      = redirect;
    if (redirect) begin
      pc_d         = pair_base(target);
      skip_first_d = target[2];
    end else if (imemReq) begin
      pc_d         = pair_base(pc_q) + PAIR_BYTES;
      inflight_d   = 1'b1;
      tag_d        = skip_first_q;
      resp_base_d  = pair_base(pc_q);
      skip_first_d = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      skip_first_q <= RESET_PC[2];
      inflight_q   <= 1'b0;
      tag_q        <= 1'b0;
      resp_base_q  <= '0;
      flush_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      skip_first_q <= skip_first_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      resp_base_q  <= resp_base_d;
      flush_q      <= flush_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (resp_live),
    .push_data (resp_entry),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign fetchValid  = !q_empty;
  assign fetchValid1 = !q_empty && q_head.v1;
  assign fetchValid2 = !q_empty && q_head.v2;
  assign fetchPc1    = q_head.pc;
  assign fetchPc2    = q_head.pc + INSTR_BYTES;
  assign fetchInst1  = q_head.inst1;
  assign fetchInst2  = q_head.inst2;
  assign flush       = flush_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: PC-coded instruction memory, a stream-level
// model of the pair sequence decode should observe, and directed scenarios.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 4;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemInst1, imemInst2;
  logic        isBranchTaken1, isBranchTaken2;
  logic [31:0] branchPC1, branchPC2;
  logic        decodeReady;
  logic        fetchValid, fetchValid1, fetchValid2;
  logic [31:0] fetchPc1, fetchPc2, fetchInst1, fetchInst2;
  logic        flush;

  fetch_redirect_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemInst1(imemInst1), .imemInst2(imemInst2),
    .isBranchTaken1(isBranchTaken1), .branchPC1(branchPC1),
    .isBranchTaken2(isBranchTaken2), .branchPC2(branchPC2),
    .decodeReady(decodeReady),
    .fetchValid(fetchValid), .fetchValid1(fetchValid1), .fetchValid2(fetchValid2),
    .fetchPc1(fetchPc1), .fetchPc2(fetchPc2),
    .fetchInst1(fetchInst1), .fetchInst2(fetchInst2),
    .flush(flush)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] code(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // ---------------- instruction memory ----------------
  logic        req_seen;
  logic [31:0] addr_seen;

  always @(negedge clk) begin
    req_seen  = imemReq;
    addr_seen = imemAddr;
  end

  always @(posedge clk) begin
    #1;
    if (req_seen === 1'b1) begin
      imemInst1 = code(addr_seen);
      imemInst2 = code(addr_seen + 32'd4);
    end else begin
      imemInst1 = 32'hBAD0_0001;
      imemInst2 = 32'hBAD0_0002;
    end
  end

  // ---------------- stream model + per-cycle compare ----------------
  // The model only knows the architectural stream: after reset or a redirect
  // to T, decode sees pairs base(T), base(T)+8, ... in order, the very first
  // one with slot 1 invalid when T[2] is set; flush follows each accepted
  // redirect by one cycle; no pair is visible right after a flush.
  bit          started = 0;
  logic [31:0] m_pc;
  logic        m_skip;
  logic        m_flush_exp = 1'b0;
  logic [31:0] m_tgt;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (started) begin
      check("flush", flush, m_flush_exp);
      if (!rst_n || isBranchTaken1 || isBranchTaken2) check("req_blocked", imemReq, 0);
      if (imemReq === 1'b1) check("addr_align", imemAddr & 32'h7, 0);
      if (m_flush_exp) check("valid_after_flush", fetchValid, 0);
      if (fetchValid === 1'b1) begin
        check("pc1", fetchPc1, m_pc);
        check("pc2", fetchPc2, m_pc + 32'd4);
        check("inst1", fetchInst1, code(m_pc));
        check("inst2", fetchInst2, code(m_pc + 32'd4));
        check("v1", fetchValid1, !m_skip);
        check("v2", fetchValid2, 1);
      end
      check("push_while_full",
            dut.u_queue.push && dut.u_queue.full && !dut.u_queue.pop && !dut.u_queue.clear, 0);
    end
    m_flush_exp = rst_n && (isBranchTaken1 || isBranchTaken2);
    if (!rst_n) begin
      m_pc    = RESET_PC & 32'hFFFF_FFF8;
      m_skip  = RESET_PC[2];
      started = 1;
    end else if (isBranchTaken1 || isBranchTaken2) begin
      m_tgt  = isBranchTaken1 ? branchPC1 : branchPC2;
      m_pc   = m_tgt & 32'hFFFF_FFF8;
      m_skip = m_tgt[2];
    end else if (fetchValid && decodeReady) begin
      m_pc   = m_pc + 32'd8;
      m_skip = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic dr);
    tick();
    rst_n       = 1'b0;
    decodeReady = dr;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect1(input logic [31:0] t);
    isBranchTaken1 = 1'b1;
    branchPC1      = t;
  endtask

  task automatic clear_branches();
    isBranchTaken1 = 1'b0;
    isBranchTaken2 = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (fetchValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (fetchValid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: fetchValid timeout, got %b expected 1", name, fetchValid);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0; decodeReady = 1'b1;
    isBranchTaken1 = 1'b0; isBranchTaken2 = 1'b0;
    branchPC1 = '0; branchPC2 = '0;
    imemInst1 = '0; imemInst2 = '0;

    // 1: reset then streaming with decode always ready
    tick(); tick();
    @(negedge clk);
    check("rst_req", imemReq, 0);
    check("rst_valid", fetchValid, 0);
    check("rst_flush", flush, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_valid_c0", fetchValid, 0);
    check("t1_req_c0", imemReq, 1);
    check("t1_addr_c0", imemAddr, 32'h0);
    @(negedge clk);
    check("t1_valid_c1", fetchValid, 0);
    @(negedge clk);
    check("t1_valid_c2", fetchValid, 1);
    check("t1_pc_a", fetchPc1, 32'h00);
    check("t1_v1", fetchValid1, 1);
    check("t1_v2", fetchValid2, 1);
    @(negedge clk);
    check("t1_pc_b", fetchPc1, 32'h08);
    @(negedge clk);
    check("t1_pc_c", fetchPc1, 32'h10);

    // 2: decode stalled fills the queue, then drains in order
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    check("t2_full_valid", fetchValid, 1);
    check("t2_full_req", imemReq, 0);
    check("t2_head", fetchPc1, 32'h00);
    tick();
    decodeReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_q.push_back(32'(i * 8));
      check("t2_drain", fetchPc1, exp_q.pop_front());
    end

    // 3: redirect with 3 queued pairs and one response in flight
    do_reset(1'b0);
    repeat (4) @(posedge clk);
    #1;
    redirect1(32'h40);
    @(negedge clk);
    check("t3_req_in_redirect", imemReq, 0);
    check("t3_valid_before", fetchValid, 1);
    tick();
    clear_branches();
    decodeReady = 1'b1;
    @(negedge clk);
    check("t3_flush", flush, 1);
    check("t3_valid_flushed", fetchValid, 0);
    @(negedge clk);
    check("t3_flush_pulse", flush, 0);
    wait_valid("t3_wait");
    check("t3_target", fetchPc1, 32'h40);

    // 4: both slots taken, older slot wins
    tick();
    isBranchTaken1 = 1'b1; branchPC1 = 32'h100;
    isBranchTaken2 = 1'b1; branchPC2 = 32'h200;
    tick();
    clear_branches();
    wait_valid("t4_wait");
    check("t4_target", fetchPc1, 32'h100);

    // 5: target in the second word of a pair
    tick();
    isBranchTaken2 = 1'b1; branchPC2 = 32'h44;
    tick();
    clear_branches();
    wait_valid("t5_wait");
    check("t5_pc", fetchPc1, 32'h40);
    check("t5_v1", fetchValid1, 0);
    check("t5_v2", fetchValid2, 1);
    @(negedge clk);
    check("t5_next_pc", fetchPc1, 32'h48);
    check("t5_next_v1", fetchValid1, 1);

    // 7: back-to-back redirects, the last one wins
    tick();
    redirect1(32'h500);
    tick();
    redirect1(32'h600);
    tick();
    clear_branches();
    wait_valid("t7_wait");
    check("t7_target", fetchPc1, 32'h600);

    // 6: reset while full and a redirect is asserted
    tick();
    decodeReady = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    redirect1(32'h300);
    @(negedge clk);
    check("t6_req_in_reset", imemReq, 0);
    tick();
    rst_n = 1'b1;
    clear_branches();
    decodeReady = 1'b1;
    @(negedge clk);
    check("t6_flush", flush, 0);
    check("t6_valid", fetchValid, 0);
    check("t6_addr", imemAddr, RESET_PC);
    check("t6_req", imemReq, 1);
    wait_valid("t6_wait");
    check("t6_restart", fetchPc1, RESET_PC);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
